clk_cfg_arbiter: RTL

Shares the three clock-generator configuration channels (soc, per, cluster) between NUM_REQ on-chip requesters, for example the APB config slave and the boot sequencer.
- Arbitrates round-robin, one transaction in flight at a time.
- Runs the 4-phase req/ack handshake on the selected channel.
- Returns read data or error to the winning requester, with a timeout.
- Sits between the SoC control bus and clk_gen.

---
 rtl/clk_cfg_arbiter_if.sv | 27 ++
 rtl/clk_cfg_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_cfg_arbiter_if.sv
// Requester-side bus of clk_cfg_arbiter: request fields in, grant and response out.
// Signal names carry their direction as seen from the arbiter.
// slave modport  = the arbiter.
// master modport = the requesters (APB config slave, boot sequencer, ...).
interface clk_cfg_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [2*NUM_REQ-1:0]  req_tgt_i;
    logic [2*NUM_REQ-1:0]  req_add_i;
    logic [32*NUM_REQ-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]    req_wrn_i;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [31:0]           rsp_rdata_o;
    logic                  rsp_err_o;

    modport slave (
        input  req_valid_i, req_tgt_i, req_add_i, req_wdata_i, req_wrn_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_tgt_i, req_add_i, req_wdata_i, req_wrn_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/clk_cfg_arbiter.sv
// clk_cfg_arbiter: shares the soc/per/cluster clock-generator config channels
// between NUM_REQ requesters.
// - Round-robin arbitration, one transaction in flight at a time.
// - Runs a 4-phase req/ack handshake on the selected channel.
// - Each handshake phase has a timeout.
// Optional feature macro: CLK_CFG_LOCK_WAIT_EN. When defined, a successful
// write waits for the target lock input before responding.
// TIMEOUT_CYC must be smaller than 2**TO_W.
module clk_cfg_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic              ref_clk_i,
    input  logic              rstn_glob_i,
    clk_cfg_arbiter_if.slave  bus,

    output logic              soc_cfg_req_o,
    input  logic              soc_cfg_ack_i,
    output logic [1:0]        soc_cfg_add_o,
    output logic [31:0]       soc_cfg_data_o,
    output logic              soc_cfg_wrn_o,
    input  logic [31:0]       soc_cfg_r_data_i,
    input  logic              soc_cfg_lock_i,

    output logic              per_cfg_req_o,
    input  logic              per_cfg_ack_i,
    output logic [1:0]        per_cfg_add_o,
    output logic [31:0]       per_cfg_data_o,
    output logic              per_cfg_wrn_o,
    input  logic [31:0]       per_cfg_r_data_i,
    input  logic              per_cfg_lock_i,

    output logic              cluster_cfg_req_o,
    input  logic              cluster_cfg_ack_i,
    output logic [1:0]        cluster_cfg_add_o,
    output logic [31:0]       cluster_cfg_data_o,
    output logic              cluster_cfg_wrn_o,
    input  logic [31:0]       cluster_cfg_r_data_i,
    input  logic              cluster_cfg_lock_i,

    output logic [2:0]        lock_o,
    output logic              busy_o
);

    localparam int              ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RELEASE,
`ifdef CLK_CFG_LOCK_WAIT_EN
        ST_WAIT_LOCK,
`endif
        ST_RESP
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;

    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_id;
    logic [1:0]          r_tgt;
    logic                r_wrn;
    logic [TO_W-1:0]     r_cnt;
    logic                r_txErr;
    logic [31:0]         r_txRdata;
    logic                r_rspErr;
    logic [31:0]         r_rspRdata;
    logic [2:0]          r_chReq;
    logic [2:0][1:0]     r_chAdd;
    logic [2:0][31:0]    r_chData;
    logic [2:0]          r_chWrn;
    logic [2:0]          r_lock;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic                w_accept;
    logic [1:0]          w_selTgt;
    logic [1:0]          w_selAdd;
    logic [31:0]         w_selWdata;
    logic                w_selWrn;
    logic [1:0]          w_curTgt;
    logic                w_tgtAck;
    logic [31:0]         w_tgtRdata;
    logic                w_timeout;
    logic                w_counting;
    logic                w_txErrNext;
    logic [31:0]         w_txRdataNext;
    logic                w_rspLoad;
`ifdef CLK_CFG_LOCK_WAIT_EN
    logic                w_tgtLock;
`endif

    // Round-robin search: first valid requester after the last winner, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && bus.req_valid_i[(int'(r_last) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    // Winner's request fields and the accept condition.
    // Accept is gated by reset so that ready stays low while reset is asserted.
    always_comb begin
        w_selTgt   = bus.req_tgt_i[2*int'(w_winner) +: 2];
        w_selAdd   = bus.req_add_i[2*int'(w_winner) +: 2];
        w_selWdata = bus.req_wdata_i[32*int'(w_winner) +: 32];
        w_selWrn   = bus.req_wrn_i[int'(w_winner)];
        w_accept   = (r_state == ST_IDLE) && w_found && rstn_glob_i;
        w_curTgt   = w_accept ? w_selTgt : r_tgt;
    end

    // Route ack, read data and (optionally) lock from the latched target channel.
    always_comb begin
        w_tgtAck   = 1'b0;
        w_tgtRdata = '0;
`ifdef CLK_CFG_LOCK_WAIT_EN
        w_tgtLock  = 1'b0;
`endif
        case (r_tgt)
            2'b00: begin
                w_tgtAck   = soc_cfg_ack_i;
                w_tgtRdata = soc_cfg_r_data_i;
`ifdef CLK_CFG_LOCK_WAIT_EN
                w_tgtLock  = soc_cfg_lock_i;
`endif
            end
            2'b01: begin
                w_tgtAck   = per_cfg_ack_i;
                w_tgtRdata = per_cfg_r_data_i;
`ifdef CLK_CFG_LOCK_WAIT_EN
                w_tgtLock  = per_cfg_lock_i;
`endif
            end
            2'b10: begin
                w_tgtAck   = cluster_cfg_ack_i;
                w_tgtRdata = cluster_cfg_r_data_i;
`ifdef CLK_CFG_LOCK_WAIT_EN
                w_tgtLock  = cluster_cfg_lock_i;
`endif
            end
            default: ;
        endcase
    end

    // Timeout detection; the counter only runs in the waiting states.
    always_comb begin
        w_timeout  = (r_cnt == TO_LIMIT);
        w_counting = (r_state == ST_ISSUE) || (r_state == ST_RELEASE);
`ifdef CLK_CFG_LOCK_WAIT_EN
        if (r_state == ST_WAIT_LOCK) begin
            w_counting = 1'b1;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // FSM next-state logic; ack wins over a timeout that lands in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_stateNext = (w_selTgt == 2'b11) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_tgtAck || w_timeout) begin
                    w_stateNext = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!w_tgtAck) begin
`ifdef CLK_CFG_LOCK_WAIT_EN
                    w_stateNext = (!r_wrn && !r_txErr) ? ST_WAIT_LOCK : ST_RESP;
`else
                    w_stateNext = ST_RESP;
`endif
                end else if (w_timeout) begin
                    w_stateNext = ST_RESP;
                end
            end
`ifdef CLK_CFG_LOCK_WAIT_EN
            ST_WAIT_LOCK: begin
                if (w_tgtLock || w_timeout) begin
                    w_stateNext = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: grant pulse, response pulse and busy flag.
    always_comb begin
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.req_ready_o[r] = w_accept && (w_winner == ID_W'(r));
            bus.rsp_valid_o[r] = (r_state == ST_RESP) && (r_id == ID_W'(r));
        end
        busy_o = (r_state != ST_IDLE);
    end

    // Working error / read-data values for the transaction in flight.
    always_comb begin
        w_txErrNext   = r_txErr;
        w_txRdataNext = r_txRdata;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_txErrNext   = (w_selTgt == 2'b11);
                    w_txRdataNext = '0;
                end
            end
            ST_ISSUE: begin
                if (w_tgtAck) begin
                    w_txRdataNext = r_wrn ? w_tgtRdata : 32'h0;
                end else if (w_timeout) begin
                    w_txErrNext = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (w_tgtAck && w_timeout) begin
                    w_txErrNext = 1'b1;
                end
            end
`ifdef CLK_CFG_LOCK_WAIT_EN
            ST_WAIT_LOCK: begin
                if (!w_tgtLock && w_timeout) begin
                    w_txErrNext = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        w_rspLoad = (w_stateNext == ST_RESP) && (r_state != ST_RESP);
    end

    // Latch the winner's control fields, track round-robin and transaction result.
    always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            r_last     <= ID_W'(NUM_REQ - 1);
            r_id       <= '0;
            r_tgt      <= '0;
            r_wrn      <= 1'b0;
            r_txErr    <= 1'b0;
            r_txRdata  <= '0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            if (w_accept) begin
                r_last <= w_winner;
                r_id   <= w_winner;
                r_tgt  <= w_selTgt;
                r_wrn  <= w_selWrn;
            end
            r_txErr   <= w_txErrNext;
            r_txRdata <= w_txRdataNext;
            if (w_rspLoad) begin
                r_rspErr   <= w_txErrNext;
                r_rspRdata <= w_txRdataNext;
            end
        end
    end

    // Per-phase timeout counter, cleared on every state change.
    always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            r_cnt <= '0;
        end else if (w_stateNext != r_state) begin
            r_cnt <= '0;
        end else if (w_counting) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Channel drive registers: only the latched target channel carries non-zero values.
    always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            r_chReq  <= '0;
            r_chAdd  <= '0;
            r_chData <= '0;
            r_chWrn  <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                r_chReq[c] <= (w_stateNext == ST_ISSUE) && (w_curTgt == 2'(c));
                if (w_accept) begin
                    r_chAdd[c]  <= (w_selTgt == 2'(c)) ? w_selAdd   : 2'b00;
                    r_chData[c] <= (w_selTgt == 2'(c)) ? w_selWdata : 32'h0;
                    r_chWrn[c]  <= (w_selTgt == 2'(c)) ? w_selWrn   : 1'b0;
                end
            end
        end
    end

    // Registered copy of the lock inputs, {cluster, per, soc}.
    always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            r_lock <= '0;
        end else begin
            r_lock <= {cluster_cfg_lock_i, per_cfg_lock_i, soc_cfg_lock_i};
        end
    end

    assign bus.rsp_rdata_o = r_rspRdata;
    assign bus.rsp_err_o   = r_rspErr;
    assign lock_o          = r_lock;

    assign soc_cfg_req_o      = r_chReq[0];
    assign soc_cfg_add_o      = r_chAdd[0];
    assign soc_cfg_data_o     = r_chData[0];
    assign soc_cfg_wrn_o      = r_chWrn[0];
    assign per_cfg_req_o      = r_chReq[1];
    assign per_cfg_add_o      = r_chAdd[1];
    assign per_cfg_data_o     = r_chData[1];
    assign per_cfg_wrn_o      = r_chWrn[1];
    assign cluster_cfg_req_o  = r_chReq[2];
    assign cluster_cfg_add_o  = r_chAdd[2];
    assign cluster_cfg_data_o = r_chData[2];
    assign cluster_cfg_wrn_o  = r_chWrn[2];

endmodule
